// File: rtl/fetch_queue.sv
// Instruction-fetch front end. It generates sequential PCs, issues credit-limited memory requests
// that accept in-order responses of variable latency, and buffers results in a first-word fall-through queue.
module fetch_queue #(
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      DEPTH    = 4
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Redirect,
    input  logic [XLEN-1:0]         i_Redirect_PC,
    output logic                    o_Mem_Req,
    output logic [XLEN-1:0]         o_Mem_Addr,
    input  logic                    i_Mem_Gnt,
    input  logic                    i_Mem_Rvalid,
    input  logic [31:0]             i_Mem_Rdata,
    output logic                    o_Valid,
    output logic [31:0]             o_Instr,
    output logic [XLEN-1:0]         o_PC,
    input  logic                    i_Ready,
    output logic [$clog2(DEPTH):0]  o_Level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0]   ONE_C    = CW'(1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]     DEPTH_X  = (CW+1)'(DEPTH);
    localparam logic [AW-1:0]   ONE_P    = AW'(1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_pc;
    logic            issue;
    logic            rsp_ok;
    logic            drop;
    logic            push;
    logic            pop;
    logic            unused_pc_bits;

    assign redirect_pc    = {i_Redirect_PC[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^i_Redirect_PC[1:0];

    // Slots already spoken for: queued entries plus live (non-discarded) requests in flight.
    assign credit_used = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};

    // Stale requests awaiting discard still occupy the response path, so outstanding is capped at DEPTH too.
    assign o_Mem_Req  = i_Reset && !i_Redirect && (credit_used < DEPTH_X) && (outstanding < DEPTH_C);
    assign o_Mem_Addr = fetch_pc;
    assign issue      = o_Mem_Req && i_Mem_Gnt;

    assign rsp_ok = i_Mem_Rvalid && (outstanding != '0);
    assign drop   = rsp_ok && ((discard != '0) || i_Redirect);
    assign push   = rsp_ok && !drop;

    assign o_Valid = (count != '0);
    assign pop     = o_Valid && i_Ready;
    assign o_Instr = o_Valid ? instr_mem[rd_ptr] : '0;
    assign o_PC    = o_Valid ? pc_mem[rd_ptr]    : '0;
    assign o_Level = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (issue && !rsp_ok) begin
                outstanding <= outstanding + ONE_C;
            end else if (!issue && rsp_ok) begin
                outstanding <= outstanding - ONE_C;
            end

            if (i_Redirect) begin
                // No request can issue in this cycle, so the in-flight total is outstanding less this response.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                discard  <= outstanding - {{(CW-1){1'b0}}, rsp_ok};
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_ok && (discard != '0)) begin
                    discard <= discard - ONE_C;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                    wr_ptr  <= wr_ptr + ONE_P;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ONE_P;
                end
                if (push && !pop) begin
                    count <= count + ONE_C;
                end else if (!push && pop) begin
                    count <= count - ONE_C;
                end
            end
        end
    end

    // NOTE: queue storage is not reset; o_Valid gates the outputs, so stale contents are never visible.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            instr_mem[wr_ptr] <= i_Mem_Rdata;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. An in-order memory responder with selectable latency lives inside the cycle task,
// and every check compares a DUT output with a hand-computed value.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic            i_Clock       = 1'b0;
    logic            i_Reset       = 1'b0;
    logic            i_Redirect    = 1'b0;
    logic [XLEN-1:0] i_Redirect_PC = '0;
    logic            o_Mem_Req;
    logic [XLEN-1:0] o_Mem_Addr;
    logic            i_Mem_Gnt     = 1'b0;
    logic            i_Mem_Rvalid  = 1'b0;
    logic [31:0]     i_Mem_Rdata   = '0;
    logic            o_Valid;
    logic [31:0]     o_Instr;
    logic [XLEN-1:0] o_PC;
    logic            i_Ready       = 1'b0;
    logic [LW-1:0]   o_Level;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_grants = 0;

    logic [XLEN-1:0] pend_addr [$];
    int              pend_due  [$];

    fetch_queue #(.XLEN(XLEN), .RESET_PC('0), .DEPTH(DEPTH)) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_Redirect    (i_Redirect),
        .i_Redirect_PC (i_Redirect_PC),
        .o_Mem_Req     (o_Mem_Req),
        .o_Mem_Addr    (o_Mem_Addr),
        .i_Mem_Gnt     (i_Mem_Gnt),
        .i_Mem_Rvalid  (i_Mem_Rvalid),
        .i_Mem_Rdata   (i_Mem_Rdata),
        .o_Valid       (o_Valid),
        .o_Instr       (o_Instr),
        .o_PC          (o_PC),
        .i_Ready       (i_Ready),
        .o_Level       (o_Level)
    );

    always #5 i_Clock = ~i_Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        return 32'hA000_0000 ^ a[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record a grant before the edge, then present any response that is due in the new cycle.
    task automatic cycle();
        #1;
        if (o_Mem_Req && i_Mem_Gnt) begin
            pend_addr.push_back(o_Mem_Addr);
            pend_due.push_back(cyc + lat);
            n_grants++;
        end
        @(posedge i_Clock);
        cyc++;
        #1;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            i_Mem_Rvalid = 1'b1;
            i_Mem_Rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            i_Mem_Rvalid = 1'b0;
            i_Mem_Rdata  = '0;
        end
    endtask

    task automatic apply_reset();
        i_Reset      = 1'b0;
        i_Redirect   = 1'b0;
        i_Mem_Gnt    = 1'b0;
        i_Ready      = 1'b0;
        i_Mem_Rvalid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        cycle();
        cycle();
        i_Reset  = 1'b1;
        n_grants = 0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", 64'(o_Valid), 64'd0);
        check("rst_level", 64'(o_Level), 64'd0);
        check("rst_req",   64'(o_Mem_Req), 64'd0);
        check("rst_instr", 64'(o_Instr), 64'd0);
        check("rst_pc",    o_PC, 64'd0);

        // 1: streaming, grant every cycle, latency 1, ready high
        i_Mem_Gnt = 1'b1; i_Ready = 1'b1; lat = 1;
        cycle(); cycle();
        i_Reset = 1'b1;
        #1;
        check("t1_req_c0",  64'(o_Mem_Req), 64'd1);
        check("t1_addr_c0", o_Mem_Addr, 64'h0);
        check("t1_valid_c0", 64'(o_Valid), 64'd0);
        cycle();
        check("t1_addr_c1", o_Mem_Addr, 64'h4);
        check("t1_valid_c1", 64'(o_Valid), 64'd0);
        cycle();
        check("t1_valid_c2", 64'(o_Valid), 64'd1);
        check("t1_pc_c2",    o_PC, 64'h0);
        check("t1_instr_c2", 64'(o_Instr), 64'hA000_0000);
        check("t1_addr_c2",  o_Mem_Addr, 64'h8);
        cycle();
        check("t1_pc_c3",    o_PC, 64'h4);
        check("t1_instr_c3", 64'(o_Instr), 64'hA000_0004);
        check("t1_level_c3", 64'(o_Level), 64'd1);
        cycle();
        check("t1_pc_c4",    o_PC, 64'h8);

        // 2: decode stalled, credits stop requests at DEPTH
        apply_reset();
        i_Mem_Gnt = 1'b1; lat = 1;
        repeat (5) cycle();
        #1;
        check("t2_req_full",   64'(o_Mem_Req), 64'd0);
        check("t2_level_full", 64'(o_Level), 64'd4);
        check("t2_grants",     64'(n_grants), 64'd4);
        check("t2_head_pc",    o_PC, 64'h0);
        i_Ready = 1'b1;
        cycle();
        i_Ready = 1'b0;
        #1;
        check("t2_req_after_pop",  64'(o_Mem_Req), 64'd1);
        check("t2_addr_after_pop", o_Mem_Addr, 64'h10);
        check("t2_level_after_pop", 64'(o_Level), 64'd3);
        check("t2_head_after_pop", o_PC, 64'h4);
        cycle(); cycle();
        check("t2_level_refill", 64'(o_Level), 64'd4);
        check("t2_grants_refill", 64'(n_grants), 64'd5);

        // 3: grant withheld, then latency 3
        apply_reset();
        i_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_req_hold",  64'(o_Mem_Req), 64'd1);
            check("t3_addr_hold", o_Mem_Addr, 64'h0);
            cycle();
        end
        check("t3_no_grants", 64'(n_grants), 64'd0);
        i_Mem_Gnt = 1'b1; lat = 3;
        cycle();
        i_Mem_Gnt = 1'b0;
        check("t3_addr_next", o_Mem_Addr, 64'h4);
        check("t3_valid_g1",  64'(o_Valid), 64'd0);
        cycle(); cycle();
        check("t3_valid_g3",  64'(o_Valid), 64'd0);
        cycle();
        check("t3_valid_g4",  64'(o_Valid), 64'd1);
        check("t3_pc_g4",     o_PC, 64'h0);
        check("t3_instr_g4",  64'(o_Instr), 64'hA000_0000);

        // 4: redirect with three requests in flight; target low bits ignored
        apply_reset();
        i_Ready = 1'b1; i_Mem_Gnt = 1'b1; lat = 10;
        repeat (3) cycle();
        i_Redirect = 1'b1; i_Redirect_PC = 64'h203; lat = 1;
        #1;
        check("t4_req_redirect", 64'(o_Mem_Req), 64'd0);
        cycle();
        i_Redirect = 1'b0;
        #1;
        check("t4_req_after", 64'(o_Mem_Req), 64'd1);
        check("t4_addr_after", o_Mem_Addr, 64'h200);
        cycle();
        i_Mem_Gnt = 1'b0;
        repeat (8) cycle();
        check("t4_stale_dropped", 64'(o_Valid), 64'd0);
        check("t4_stale_level",   64'(o_Level), 64'd0);
        cycle();
        check("t4_valid_target", 64'(o_Valid), 64'd1);
        check("t4_pc_target",    o_PC, 64'h200);
        check("t4_instr_target", 64'(o_Instr), 64'hA000_0200);

        // 5: redirect coinciding with a response and a pop, two entries queued
        apply_reset();
        i_Mem_Gnt = 1'b1; lat = 1;
        cycle(); cycle();
        lat = 2;
        cycle();
        lat = 1;
        cycle();
        check("t5_level_pre", 64'(o_Level), 64'd2);
        check("t5_head_pre",  o_PC, 64'h0);
        i_Redirect = 1'b1; i_Redirect_PC = 64'h1000; i_Ready = 1'b1;
        #1;
        check("t5_req_redirect", 64'(o_Mem_Req), 64'd0);
        cycle();
        i_Redirect = 1'b0;
        #1;
        check("t5_valid_flushed", 64'(o_Valid), 64'd0);
        check("t5_level_flushed", 64'(o_Level), 64'd0);
        check("t5_req_target",    64'(o_Mem_Req), 64'd1);
        check("t5_addr_target",   o_Mem_Addr, 64'h1000);
        cycle();
        i_Mem_Gnt = 1'b0;
        check("t5_old_dropped", 64'(o_Valid), 64'd0);
        cycle();
        check("t5_valid_target", 64'(o_Valid), 64'd1);
        check("t5_pc_target",    o_PC, 64'h1000);
        check("t5_instr_target", 64'(o_Instr), 64'hA000_1000);

        // 6: asynchronous reset mid-stream, stray response, then address wrap
        apply_reset();
        i_Mem_Gnt = 1'b1; lat = 1;
        repeat (3) cycle();
        check("t6_valid_pre", 64'(o_Valid), 64'd1);
        i_Reset = 1'b0;
        i_Mem_Rvalid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        #1;
        check("t6_async_valid", 64'(o_Valid), 64'd0);
        check("t6_async_level", 64'(o_Level), 64'd0);
        check("t6_async_req",   64'(o_Mem_Req), 64'd0);
        check("t6_async_instr", 64'(o_Instr), 64'd0);
        check("t6_async_pc",    o_PC, 64'd0);
        i_Mem_Gnt = 1'b0;
        cycle(); cycle();
        i_Reset = 1'b1;
        #1;
        check("t6_restart_req",  64'(o_Mem_Req), 64'd1);
        check("t6_restart_addr", o_Mem_Addr, 64'h0);
        i_Mem_Rvalid = 1'b1; i_Mem_Rdata = 32'hDEAD_BEEF;
        cycle();
        check("t6_stray_level", 64'(o_Level), 64'd0);
        check("t6_stray_valid", 64'(o_Valid), 64'd0);
        n_grants = 0; i_Mem_Gnt = 1'b1; i_Ready = 1'b0; lat = 1;
        repeat (5) cycle();
        check("t6_refill_level",  64'(o_Level), 64'd4);
        check("t6_refill_grants", 64'(n_grants), 64'd4);

        apply_reset();
        i_Ready = 1'b1;
        i_Redirect = 1'b1; i_Redirect_PC = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        i_Redirect = 1'b0; i_Mem_Gnt = 1'b1; lat = 1;
        #1;
        check("t6_wrap_addr_top", o_Mem_Addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        check("t6_wrap_addr_zero", o_Mem_Addr, 64'h0);
        cycle();
        i_Mem_Gnt = 1'b0;
        check("t6_wrap_valid", 64'(o_Valid), 64'd1);
        check("t6_wrap_pc_top", o_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t6_wrap_instr_top", 64'(o_Instr), 64'h5FFF_FFFC);
        cycle();
        check("t6_wrap_pc_zero", o_PC, 64'h0);
        check("t6_wrap_instr_zero", 64'(o_Instr), 64'hA000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
